// File: rtl/kamikaze_pkg.sv
// Shared AHB-Lite constants and the address-phase record used by the kamikaze
// bus arbiter and its per-master hold buffers.
package kamikaze_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  typedef struct packed {
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [3:0]  hprot;
  } ahb_aph_t;

endpackage

// File: rtl/kamikaze_ahb_hold.sv
// Per-master address-phase hold buffer: keeps a request that lost arbitration
// and presents either the held entry or the live master request.
module kamikaze_ahb_hold
  import kamikaze_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_htrans,
  input  ahb_aph_t   i_live,
  input  logic       i_mst_hready,
  input  logic       i_win,
  output logic       o_req,
  output ahb_aph_t   o_aph,
  output logic [1:0] o_htrans,
  output logic       o_hold_valid
);

  logic     r_valid;
  ahb_aph_t r_aph;
  logic     w_live_req;
  logic     w_capture;

  assign w_live_req = i_htrans[1];
  // A live request is taken from the master whenever its hready was high;
  // if it is not issued right away it must be parked here.
  assign w_capture  = !r_valid && i_mst_hready && w_live_req && !i_win;

  assign o_req        = r_valid || w_live_req;
  assign o_aph        = r_valid ? r_aph : i_live;
  assign o_htrans     = r_valid ? HTRANS_NONSEQ : i_htrans;
  assign o_hold_valid = r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_aph   <= '0;
    end else if (r_valid && i_win) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_aph   <= i_live;
    end
  end

endmodule

// File: rtl/kamikaze_ahb_arbiter.sv
// Two-master AHB-Lite arbiter (fetch = I, load/store = D) onto one bus.
// Define KMKZ_ARB_ROUND_ROBIN_EN for round-robin contention; default is D-first.
module kamikaze_ahb_arbiter
  import kamikaze_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] i_haddr_i,
  input  logic [1:0]  i_htrans_i,
  input  logic [2:0]  i_hsize_i,
  input  logic        i_hwrite_i,
  input  logic [3:0]  i_hprot_i,
  input  logic [31:0] i_hwdata_i,
  output logic        i_hready_o,
  output logic [31:0] i_hrdata_o,
  output logic        i_hresp_o,
  input  logic [31:0] d_haddr_i,
  input  logic [1:0]  d_htrans_i,
  input  logic [2:0]  d_hsize_i,
  input  logic        d_hwrite_i,
  input  logic [3:0]  d_hprot_i,
  input  logic [31:0] d_hwdata_i,
  output logic        d_hready_o,
  output logic [31:0] d_hrdata_o,
  output logic        d_hresp_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  ahb_aph_t   w_i_live, w_d_live, w_i_aph, w_d_aph, w_bus_aph, r_aph;
  logic [1:0] w_i_htrans, w_d_htrans, w_bus_htrans, r_aph_htrans;
  logic       w_i_req, w_d_req, w_i_hold, w_d_hold;
  logic       w_arb_en, w_win_valid, w_win_id, w_contend_id;
  logic       r_aph_valid, r_dph_valid, r_dph_id;
  logic       w_i_dph, w_d_dph;

  assign w_i_live = '{haddr: i_haddr_i, hsize: i_hsize_i, hwrite: i_hwrite_i, hprot: i_hprot_i};
  assign w_d_live = '{haddr: d_haddr_i, hsize: d_hsize_i, hwrite: d_hwrite_i, hprot: d_hprot_i};

  kamikaze_ahb_hold u_hold_i (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_htrans     (i_htrans_i),
    .i_live       (w_i_live),
    .i_mst_hready (i_hready_o),
    .i_win        (w_win_valid && (w_win_id == MST_I)),
    .o_req        (w_i_req),
    .o_aph        (w_i_aph),
    .o_htrans     (w_i_htrans),
    .o_hold_valid (w_i_hold)
  );

  kamikaze_ahb_hold u_hold_d (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_htrans     (d_htrans_i),
    .i_live       (w_d_live),
    .i_mst_hready (d_hready_o),
    .i_win        (w_win_valid && (w_win_id == MST_D)),
    .o_req        (w_d_req),
    .o_aph        (w_d_aph),
    .o_htrans     (w_d_htrans),
    .o_hold_valid (w_d_hold)
  );

`ifdef KMKZ_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_grant <= MST_I;
    end else if (HREADY && w_win_valid) begin
      r_last_grant <= w_win_id;
    end
  end

  assign w_contend_id = ~r_last_grant;
`else
  assign w_contend_id = MST_D;
`endif

  // Grants are only decided while the bus accepts an address phase.
  assign w_arb_en = HREADY && rst_n_i;

  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = MST_I;
    if (w_arb_en) begin
      if (w_i_req && w_d_req) begin
        w_win_valid = 1'b1;
        w_win_id    = w_contend_id;
      end else if (w_d_req) begin
        w_win_valid = 1'b1;
        w_win_id    = MST_D;
      end else if (w_i_req) begin
        w_win_valid = 1'b1;
        w_win_id    = MST_I;
      end
    end
  end

  // During wait states the previously driven address phase is replayed
  // from registers so the bus stays stable.
  always_comb begin
    w_bus_aph    = w_i_live;
    w_bus_htrans = HTRANS_IDLE;
    if (w_arb_en) begin
      if (w_win_valid) begin
        w_bus_aph    = (w_win_id == MST_D) ? w_d_aph : w_i_aph;
        w_bus_htrans = (w_win_id == MST_D) ? w_d_htrans : w_i_htrans;
      end
    end else if (r_aph_valid) begin
      w_bus_aph    = r_aph;
      w_bus_htrans = r_aph_htrans;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_aph_valid  <= 1'b0;
      r_aph        <= '0;
      r_aph_htrans <= HTRANS_IDLE;
      r_dph_valid  <= 1'b0;
      r_dph_id     <= MST_I;
    end else if (HREADY) begin
      r_aph_valid  <= w_win_valid;
      r_aph        <= w_bus_aph;
      r_aph_htrans <= w_bus_htrans;
      r_dph_valid  <= w_win_valid;
      r_dph_id     <= w_win_id;
    end
  end

  assign w_i_dph = r_dph_valid && (r_dph_id == MST_I);
  assign w_d_dph = r_dph_valid && (r_dph_id == MST_D);

  assign HADDR     = w_bus_aph.haddr;
  assign HSIZE     = w_bus_aph.hsize;
  assign HWRITE    = w_bus_aph.hwrite;
  assign HPROT     = w_bus_aph.hprot;
  assign HTRANS    = w_bus_htrans;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = w_d_dph ? d_hwdata_i : (w_i_dph ? i_hwdata_i : 32'h0);

  assign i_hready_o = w_i_dph ? HREADY : !w_i_hold;
  assign d_hready_o = w_d_dph ? HREADY : !w_d_hold;
  assign i_hresp_o  = w_i_dph && HRESP;
  assign d_hresp_o  = w_d_dph && HRESP;
  assign i_hrdata_o = HRDATA;
  assign d_hrdata_o = HRDATA;

endmodule

// File: tb/tb_kamikaze_ahb_arbiter.sv
// Self-checking bench for kamikaze_ahb_arbiter: directed scenarios followed by
// random master/slave traffic compared each cycle against a reference model.
module tb_kamikaze_ahb_arbiter;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [3:0]  prot;
  } req_t;

`ifdef KMKZ_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  req_t        live [2];
  logic [31:0] wdata [2];
  logic        hready_in, hresp_in;
  logic [31:0] hrdata_in;

  logic        i_hready, d_hready, i_hresp, d_hresp, hwrite, hmastlock;
  logic [31:0] i_hrdata, d_hrdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        pend_v [2];
  req_t        pend [2];
  int          owner;
  logic        bus_v;
  req_t        bus_last;
  int          last_win;
  int          win;
  req_t        ex_bus;
  logic        ex_hready [2];
  logic        ex_hresp [2];
  logic [31:0] ex_hwdata;

  always #5 clk = ~clk;

  kamikaze_ahb_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .i_haddr_i(live[0].addr), .i_htrans_i(live[0].trans), .i_hsize_i(live[0].size),
    .i_hwrite_i(live[0].wr), .i_hprot_i(live[0].prot), .i_hwdata_i(wdata[0]),
    .i_hready_o(i_hready), .i_hrdata_o(i_hrdata), .i_hresp_o(i_hresp),
    .d_haddr_i(live[1].addr), .d_htrans_i(live[1].trans), .d_hsize_i(live[1].size),
    .d_hwrite_i(live[1].wr), .d_hprot_i(live[1].prot), .d_hwdata_i(wdata[1]),
    .d_hready_o(d_hready), .d_hrdata_o(d_hrdata), .d_hresp_o(d_hresp),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HPROT(hprot),
    .HWDATA(hwdata), .HBURST(hburst), .HMASTLOCK(hmastlock),
    .HRDATA(hrdata_in), .HREADY(hready_in), .HRESP(hresp_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    owner     = -1;
    bus_v     = 1'b0;
    last_win  = 0;
  endtask

  task automatic model_eval();
    req_t eff [2];
    logic want [2];
    for (int m = 0; m < 2; m++) begin
      eff[m]  = pend_v[m] ? pend[m] : live[m];
      want[m] = pend_v[m] || live[m].trans[1];
    end
    win = -1;
    if (rst_n && hready_in) begin
      if (want[0] && want[1]) win = RR ? (1 - last_win) : 1;
      else if (want[1]) win = 1;
      else if (want[0]) win = 0;
    end
    if (win >= 0) begin
      ex_bus = eff[win];
    end else if (!(rst_n && hready_in) && bus_v) begin
      ex_bus = bus_last;
    end else begin
      ex_bus = live[0];
      ex_bus.trans = 2'b00;
    end
    for (int m = 0; m < 2; m++) begin
      ex_hready[m] = (owner == m) ? hready_in : !pend_v[m];
      ex_hresp[m]  = (owner == m) ? hresp_in : 1'b0;
    end
    ex_hwdata = (owner >= 0) ? wdata[owner] : 32'h0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (win == m) begin
        pend_v[m] = 1'b0;
      end else if (!pend_v[m] && ex_hready[m] && live[m].trans[1]) begin
        pend_v[m]      = 1'b1;
        pend[m]        = live[m];
        pend[m].trans  = 2'b10;
      end
    end
    if (hready_in) begin
      owner    = win;
      bus_v    = (win >= 0);
      bus_last = ex_bus;
      if (win >= 0) last_win = win;
    end
  endtask

  task automatic check_now();
    model_eval();
    chk("haddr", haddr, ex_bus.addr);
    chk("htrans", {30'd0, htrans}, {30'd0, ex_bus.trans});
    chk("hsize", {29'd0, hsize}, {29'd0, ex_bus.size});
    chk("hwrite", {31'd0, hwrite}, {31'd0, ex_bus.wr});
    chk("hprot", {28'd0, hprot}, {28'd0, ex_bus.prot});
    chk("hwdata", hwdata, ex_hwdata);
    chk("i_hready", {31'd0, i_hready}, {31'd0, ex_hready[0]});
    chk("d_hready", {31'd0, d_hready}, {31'd0, ex_hready[1]});
    chk("i_hresp", {31'd0, i_hresp}, {31'd0, ex_hresp[0]});
    chk("d_hresp", {31'd0, d_hresp}, {31'd0, ex_hresp[1]});
    chk("i_hrdata", i_hrdata, hrdata_in);
    chk("d_hrdata", d_hrdata, hrdata_in);
    chk("hburst_lock", {28'd0, hburst, hmastlock}, 32'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    check_now();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int m, input logic [1:0] tr, input logic [31:0] a, input logic w);
    live[m] = '{trans: tr, addr: a, size: 3'd2, wr: w, prot: 4'h3};
  endtask

  task automatic set_idle(input int m);
    live[m].trans = 2'b00;
  endtask

  task automatic rand_master(input int m);
    logic [1:0] tr;
    case ($urandom_range(0, 3))
      0: tr = 2'b00;
      1: tr = 2'b11;
      default: tr = 2'b10;
    endcase
    live[m] = '{trans: tr, addr: $urandom, size: 3'($urandom_range(0, 2)),
                wr: 1'($urandom_range(0, 1)), prot: 4'($urandom_range(0, 15))};
  endtask

  initial begin
    model_reset();
    for (int m = 0; m < 2; m++) begin
      set_req(m, 2'b00, 32'h0, 1'b0);
      wdata[m] = 32'h0;
    end
    hready_in = 1'b1;
    hresp_in  = 1'b0;
    hrdata_in = 32'h1234_5678;

    // reset state: a live I request must not reach the bus
    set_req(0, 2'b10, 32'h0000_1234, 1'b0);
    settle();
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'h0000_1234);
    tick();
    set_idle(0);
    rst_n = 1'b1;
    settle();
    tick();

    // uncontended I request
    set_req(0, 2'b10, 32'h0000_0100, 1'b0);
    settle();
    chk("solo_haddr", haddr, 32'h0000_0100);
    chk("solo_htrans", {30'd0, htrans}, 32'd2);
    chk("solo_i_rdy", {31'd0, i_hready}, 32'd1);
    chk("solo_d_rdy", {31'd0, d_hready}, 32'd1);
    tick();
    set_idle(0);
    settle();
    tick();

    // contention: D write wins, I captured then issued
    set_req(0, 2'b10, 32'h0000_0100, 1'b0);
    set_req(1, 2'b10, 32'h2000_0000, 1'b1);
    settle();
    chk("cont_haddr_d", haddr, 32'h2000_0000);
    tick();
    set_idle(0);
    set_idle(1);
    wdata[1] = 32'hDEAD_BEEF;
    settle();
    chk("cont_haddr_i", haddr, 32'h0000_0100);
    chk("cont_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("cont_i_stall", {31'd0, i_hready}, 32'd0);
    tick();
    settle();
    chk("cont_i_done", {31'd0, i_hready}, 32'd1);
    tick();

    // repeated contention: both masters keep requesting
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++)
        if (ex_hready[m] || k == 0) set_req(m, 2'b10, (m == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(k * 4), 1'b0);
      settle();
      chk("rr_grant", {28'd0, haddr[31:28]}, (RR && (k % 2 == 1)) ? 32'd1 : 32'd2);
      tick();
    end
    set_idle(0);
    set_idle(1);
    for (int k = 0; k < 4; k++) begin
      settle();
      tick();
    end

    // D load with three wait states while I requests
    set_req(1, 2'b10, 32'h3000_0040, 1'b0);
    settle();
    tick();
    set_idle(1);
    set_req(0, 2'b10, 32'h0000_0100, 1'b0);
    hready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ws_haddr", haddr, 32'h3000_0040);
      chk("ws_htrans", {30'd0, htrans}, 32'd2);
      chk("ws_d_rdy", {31'd0, d_hready}, 32'd0);
      tick();
      set_idle(0);
    end
    hready_in = 1'b1;
    settle();
    chk("ws_i_issue", haddr, 32'h0000_0100);
    chk("ws_d_rdy_end", {31'd0, d_hready}, 32'd1);
    tick();
    settle();
    tick();

    // two-cycle ERROR on D, I held meanwhile
    set_req(1, 2'b10, 32'h4000_0000, 1'b0);
    settle();
    tick();
    set_idle(1);
    set_req(0, 2'b10, 32'h0000_0200, 1'b0);
    hready_in = 1'b0;
    hresp_in  = 1'b1;
    settle();
    chk("err1_d_resp", {31'd0, d_hresp}, 32'd1);
    chk("err1_i_resp", {31'd0, i_hresp}, 32'd0);
    tick();
    set_idle(0);
    hready_in = 1'b1;
    settle();
    chk("err2_d_resp", {31'd0, d_hresp}, 32'd1);
    chk("err2_i_resp", {31'd0, i_hresp}, 32'd0);
    chk("err_i_issue", haddr, 32'h0000_0200);
    tick();
    hresp_in = 1'b0;
    settle();
    tick();

    // reset pulse while I is held
    set_req(1, 2'b10, 32'h5000_0000, 1'b1);
    settle();
    tick();
    set_idle(1);
    set_req(0, 2'b10, 32'h0000_0300, 1'b0);
    hready_in = 1'b0;
    settle();
    tick();
    set_req(0, 2'b00, 32'h0000_0777, 1'b0);
    wdata[1] = 32'hCAFE_F00D;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstm_htrans", {30'd0, htrans}, 32'd0);
    chk("rstm_haddr", haddr, 32'h0000_0777);
    chk("rstm_hwdata", hwdata, 32'd0);
    chk("rstm_rdy", {30'd0, i_hready, d_hready}, 32'd3);
    chk("rstm_resp", {30'd0, i_hresp, d_hresp}, 32'd0);
    settle();
    tick();
    rst_n = 1'b1;
    hready_in = 1'b1;
    settle();
    chk("rstm_i_free", {31'd0, i_hready}, 32'd1);
    chk("rstm_no_replay", {30'd0, htrans}, 32'd0);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (ex_hready[m]) rand_master(m);
        wdata[m] = $urandom;
      end
      hready_in = ($urandom_range(0, 3) != 0);
      hresp_in  = ($urandom_range(0, 9) == 0);
      hrdata_in = $urandom;
      settle();
      tick();
    end
    set_idle(0);
    set_idle(1);
    hready_in = 1'b1;
    hresp_in  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamikaze_ahb_arbiter.md
# kamikaze_ahb_arbiter

Two-master AHB-Lite arbiter that shares the core's single external AHB-Lite bus between the instruction fetch unit (master I) and the load/store unit (master D). Each master gets its own full AHB-Lite slave-side port with an address-phase hold buffer, so a master whose address loses arbitration is stalled transparently. Sits between `kamikaze_fetch` / the LSU and the system bus.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk_i` in 1: core clock; all state on rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `i_haddr_i`, `d_haddr_i` in 32: master address.
- `i_htrans_i`, `d_htrans_i` in 2: master HTRANS; bit 1 set means a request (NONSEQ/SEQ).
- `i_hsize_i`, `d_hsize_i` in 3; `i_hwrite_i`, `d_hwrite_i` in 1; `i_hprot_i`, `d_hprot_i` in 4: address-phase control.
- `i_hwdata_i`, `d_hwdata_i` in 32: data-phase write data.
- `i_hready_o`, `d_hready_o` out 1; `i_hrdata_o`, `d_hrdata_o` out 32; `i_hresp_o`, `d_hresp_o` out 1: per-master response.
- `HADDR` out 32, `HTRANS` out 2, `HSIZE` out 3, `HWRITE` out 1, `HPROT` out 4, `HWDATA` out 32, `HBURST` out 3 (constant 0), `HMASTLOCK` out 1 (constant 0).
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 1: bus slave response.

## Operation
- Per master: hold register `{valid, haddr, hsize, hwrite, hprot}`. Effective request = hold.valid ? hold contents : live inputs with `htrans[1]`.
- Arbitration happens only in cycles with `HREADY`=1. With one requester, it wins. With both requesting, see Configuration. Winner drives the bus address phase combinationally: `HTRANS`=NONSEQ (2'b10), or the live `htrans` when issued live. With no requester, `HTRANS`=IDLE and the remaining address fields come from master I.
- While `HREADY`=0, the address owner and all address outputs are held stable. The owner is registered.
- Data-phase owner `dph_{valid,id}`: on `HREADY`=1, loads `{winner present, winner id}`.
- `HWDATA` = hwdata of the data-phase owner, or 0 if none. `HRDATA` fans out to both masters unchanged.
- `x_hresp_o` = `HRESP` when x is the data-phase owner, else 0.
- `x_hready_o` = `HREADY` if x is the data-phase owner; else 0 if `x.hold.valid`; else 1.
- Capture: when `x_hready_o`=1, x presents a live request, and x is not the winner, the request is latched into x's hold register.
- Release: the hold clears when its entry wins. x stays stalled until its issued data phase completes.
- Simultaneous events:
  - The data-phase owner may present its next address in the same cycle its data phase completes. That address is either granted or captured; it is never dropped.
  - At most one hold entry per master; the handshake guarantees no overflow.
- Bus ERROR response (two cycles): forwarded unchanged to the owner. Hold registers are unaffected.

## Timing
- Uncontended request: zero added latency; address is visible on `HADDR` in the same cycle.
- Contended loser: issued at the earliest after the winner's address phase is accepted, i.e. +1 cycle per lost round. The loser's own data phase follows its issue by one accepted cycle.
- Reset (async assert, sync-safe release): holds empty, `dph_valid`=0, last-grant = I.
  - Reset outputs: `HTRANS`=IDLE, `HADDR`=`i_haddr_i`, `HWDATA`=0, both `x_hready_o`=1, both `x_hresp_o`=0.
- Reset asserted mid-transfer aborts all pending and held state immediately; no transfer is replayed.

## Configuration
- `KMKZ_ARB_ROUND_ROBIN_EN` defined: on contention the master not granted last wins. Last-grant updates on every accepted grant.
- Undefined: fixed priority, D always beats I. Last-grant register is not implemented.

## Structure
- Shared package `kamikaze_pkg`:
  - HTRANS constants (`HTRANS_IDLE`, `HTRANS_NONSEQ`).
  - Master index constants (`MST_I`=0, `MST_D`=1).
  - Packed address-phase struct (`haddr`, `hsize`, `hwrite`, `hprot`).
- Sub-module `kamikaze_ahb_hold`: one per master. Contains the hold register, the effective-request mux, and the capture/release logic.

## Test plan
- Only I requests at 0x0000_0100, `HREADY`=1 → `HADDR`=0x100 same cycle, `HTRANS`=2'b10, `i_hready_o`=1, `d_hready_o`=1.
- I at 0x100 and D write at 0x2000_0000 with data 0xDEADBEEF in the same cycle, fixed priority:
  - D issued first; I captured and issued the next cycle.
  - `HWDATA`=0xDEADBEEF during D's data phase.
  - `i_hready_o`=0 until I's data phase completes.
- Same contention with `KMKZ_ARB_ROUND_ROBIN_EN`, repeated 4 times → grants alternate D, I, D, I…
- D load with slave inserting 3 wait states (`HREADY`=0) while I requests → `HADDR` and `HTRANS` stable for all 3 cycles. I issued on the 4th cycle; `d_hready_o` mirrors `HREADY`.
- Slave ERROR on D's transfer → `d_hresp_o`=1 for both cycles, `i_hresp_o`=0, I's held request still issued afterwards.
- `rst_n_i` pulsed low while I is held → all outputs take reset values immediately, hold empty after release.
